// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - rv32i program counter owner with branch/jump redirect and timed wrong-path flush
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        redirect,
  output logic        misalign_err,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] pc_n;
  logic        flush_n, redirect_n, err_n;
  logic [15:0] rcnt_n;
  logic        take;
  logic [31:0] jalr_sum, target;

  assign pc_plus4 = pc + 32'd4;
  assign take     = ex_valid & (jalr | jump | branch_taken);
  assign jalr_sum = rs1 + imm;
  // JALR clears bit 0 only; a set bit 1 still trips the misalignment halt
  assign target   = jalr ? {jalr_sum[31:1], 1'b0} : (ex_pc + imm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      cnt          <= 3'd0;
      pc           <= RESET_PC;
      flush        <= 1'b0;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
      redirect_cnt <= 16'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pc           <= pc_n;
      flush        <= flush_n;
      redirect     <= redirect_n;
      misalign_err <= err_n;
      redirect_cnt <= rcnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pc_n       = pc;
    flush_n    = flush;
    redirect_n = 1'b0;
    err_n      = misalign_err;
    rcnt_n     = redirect_cnt;
    case (state)
      RUN: begin
        if (take) begin
          if (target[1:0] == 2'b00) begin
            pc_n       = target;
            redirect_n = 1'b1;
            flush_n    = 1'b1;
            cnt_n      = CNT_INIT;
            if (redirect_cnt != 16'hFFFF) rcnt_n = redirect_cnt + 16'd1;
            state_n    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else begin
            err_n   = 1'b1;
            flush_n = 1'b1;
            state_n = HALT;
          end
        end else begin
          flush_n = 1'b0;
          if (!stall) pc_n = pc_plus4;
        end
      end
      FLUSH: begin
        // EX holds a wrong-path instruction here, so take is deliberately ignored
        if (!stall) pc_n = pc_plus4;
        if (cnt == 3'd0) begin
          flush_n = 1'b0;
          state_n = RUN;
        end else begin
          flush_n = 1'b1;
          cnt_n   = cnt - 3'd1;
        end
      end
      HALT: begin
        flush_n = 1'b1;
        err_n   = 1'b1;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, ex_valid, branch_taken, jump, jalr;
  logic [31:0] ex_pc, imm, rs1;
  logic [31:0] pc, pc_plus4, pc_b, pc_plus4_b;
  logic        flush, redirect, misalign_err;
  logic        flush_b, redirect_b, misalign_err_b;
  logic [15:0] redirect_cnt, redirect_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .branch_taken(branch_taken), .jump(jump), .jalr(jalr),
    .ex_pc(ex_pc), .imm(imm), .rs1(rs1),
    .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .redirect(redirect),
    .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
  );

  // single-cycle flush variant; lets a redirect be accepted every cycle
  pc_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .branch_taken(branch_taken), .jump(jump), .jalr(jalr),
    .ex_pc(ex_pc), .imm(imm), .rs1(rs1),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .flush(flush_b), .redirect(redirect_b),
    .misalign_err(misalign_err_b), .redirect_cnt(redirect_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_take();
    ex_valid = 0; branch_taken = 0; jump = 0; jalr = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; no_take();
    ex_pc = 0; imm = 0; rs1 = 0;
    step(); step();
    rst_n = 1;
    step(); step(); step();
    chk("pre_reset_pc", pc, 32'hC);

    // async reset mid-cycle, checked before the next edge
    #1 rst_n = 0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_flush", flush, 1'b0);
    chk("async_rst_cnt", redirect_cnt, 16'h0);
    chk("async_rst_redir", redirect, 1'b0);
    rst_n = 1;
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    step(); chk("run_pc4", pc, 32'h4);
    step(); chk("run_pc8", pc, 32'h8);

    // taken branch, backward offset; take held through FLUSH must be ignored
    ex_valid = 1; branch_taken = 1; ex_pc = 32'h100; imm = 32'hFFFF_FFF0;
    step();
    chk("br_pc", pc, 32'hF0);
    chk("br_redirect", redirect, 1'b1);
    chk("br_flush1", flush, 1'b1);
    chk("br_cnt", redirect_cnt, 16'd1);
    step();
    chk("br_ign_pc", pc, 32'hF4);
    chk("br_redirect_off", redirect, 1'b0);
    chk("br_flush2", flush, 1'b1);
    chk("br_ign_cnt", redirect_cnt, 16'd1);
    no_take();
    step();
    chk("br_flush_end", flush, 1'b0);
    chk("br_post_pc", pc, 32'hF8);

    // JALR beats jump and branch; bit 0 cleared
    ex_valid = 1; jalr = 1; jump = 1; branch_taken = 1;
    rs1 = 32'h2001; imm = 32'h4; ex_pc = 32'h500;
    step();
    chk("jalr_pc", pc, 32'h2004);
    chk("jalr_cnt", redirect_cnt, 16'd2);
    no_take();
    step(); step();
    chk("jalr_post_pc", pc, 32'h200C);
    chk("jalr_flush_end", flush, 1'b0);

    // stall holds pc; redirect overrides stall; flush length unchanged by stall
    stall = 1;
    step(); step(); step();
    chk("stall_pc", pc, 32'h200C);
    ex_valid = 1; jump = 1; ex_pc = 32'h40; imm = 32'h20;
    step();
    chk("stall_jump_pc", pc, 32'h60);
    chk("stall_jump_redir", redirect, 1'b1);
    chk("stall_jump_cnt", redirect_cnt, 16'd3);
    no_take();
    step();
    chk("stall_flush_pc", pc, 32'h60);
    chk("stall_flush2", flush, 1'b1);
    step();
    chk("stall_flush_end", flush, 1'b0);
    stall = 0;

    // pc wraps from FFFFFFFC to 0
    ex_valid = 1; jump = 1; ex_pc = 32'hFFFF_FFF0; imm = 32'h4;
    step();
    chk("wrap_tgt", pc, 32'hFFFF_FFF4);
    no_take();
    step(); step();
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    step();
    chk("wrap_pc", pc, 32'h0);

    // redirect counter saturation on the single-cycle-flush instance
    rst_n = 0; #1; rst_n = 1;
    ex_valid = 1; jump = 1; ex_pc = 32'h0; imm = 32'h0;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", redirect_cnt_b, 16'hFFFE);
    chk("sat_b_redir", redirect_b, 1'b1);
    step(); chk("sat_ffff", redirect_cnt_b, 16'hFFFF);
    step(); chk("sat_hold", redirect_cnt_b, 16'hFFFF);
    no_take();
    step();
    chk("b_flush_one", flush_b, 1'b0);
    chk("b_pc_adv", pc_b, 32'h4);

    // misaligned target halts with sticky flush; only reset recovers
    rst_n = 0; #1; rst_n = 1;
    step();
    chk("mis_pre_pc", pc, 32'h4);
    ex_valid = 1; jump = 1; ex_pc = 32'h10; imm = 32'h2;
    step();
    chk("mis_pc", pc, 32'h4);
    chk("mis_err", misalign_err, 1'b1);
    chk("mis_flush", flush, 1'b1);
    chk("mis_redir", redirect, 1'b0);
    chk("mis_cnt", redirect_cnt, 16'd0);
    no_take();
    step(); step();
    chk("halt_pc", pc, 32'h4);
    chk("halt_flush", flush, 1'b1);
    chk("halt_err", misalign_err, 1'b1);
    #1 rst_n = 0;
    #1;
    chk("halt_rst_err", misalign_err, 1'b0);
    chk("halt_rst_flush", flush, 1'b0);
    chk("halt_rst_pc", pc, 32'h0);
    rst_n = 1;
    step();
    chk("halt_exit_pc", pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter for the rv32i core.
- Consumes the branch comparator's taken bit and the EX-stage jump controls, and computes the next PC.
- Drives a timed flush of wrong-path IF/ID and ID/EX contents through a small RUN/FLUSH/HALT state machine.
- Sits directly downstream of the branch comparator and upstream of instruction fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1-7)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
stall  input  1  hazard stall; holds PC when no redirect is pending
ex_valid  input  1  EX-stage instruction is valid (not a bubble)
branch_taken  input  1  branch comparator result for the EX instruction
jump  input  1  EX instruction is JAL
jalr  input  1  EX instruction is JALR
ex_pc  input  32  PC of the EX instruction
imm  input  32  sign-extended immediate of the EX instruction
rs1  input  32  rs1 operand of the EX instruction (JALR base)
pc  output  32  current fetch PC, registered
pc_plus4  output  32  pc + 4, combinational, modulo 2^32
flush  output  1  squash IF/ID and ID/EX contents
redirect  output  1  one-cycle pulse: PC was loaded from a target
misalign_err  output  1  sticky: a redirect target was not 4-byte aligned
redirect_cnt  output  16  accepted redirects, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, flush=0, redirect=0, misalign_err=0, redirect_cnt=0, state=RUN, internal flush counter=0.
  - Reset asserted mid-FLUSH or in HALT aborts immediately.
- Redirect request: take = ex_valid & (jalr | jump | branch_taken). Evaluated only in RUN.
- Target selection, by priority:
  - jalr: (rs1 + imm) & 32'hFFFF_FFFE.
  - otherwise, jump or branch_taken: ex_pc + imm.
  - All additions are 32-bit with wrap-around; carry is discarded.
- RUN, take=1, target[1:0]==0:
  - At the next edge: pc<=target, redirect<=1, flush<=1, counter<=FLUSH_CYCLES-1, redirect_cnt increments (saturating at 16'hFFFF).
  - Next state is FLUSH if FLUSH_CYCLES>1, otherwise RUN with flush for exactly one cycle.
  - Redirect has priority over stall.
- RUN, take=1, target misaligned:
  - pc unchanged; misalign_err<=1, flush<=1, state<=HALT.
  - redirect stays 0 and redirect_cnt does not change.
- RUN, take=0:
  - stall=1: pc holds.
  - stall=0: pc<=pc+4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - flush=0, redirect=0.
- FLUSH:
  - flush=1; redirect=0 after its first cycle.
  - take is ignored (wrong-path instruction).
  - pc advances by 4 unless stall=1.
  - counter decrements each cycle; when counter==0 at an edge, flush<=0 and state<=RUN.
  - Net result: flush is high for exactly FLUSH_CYCLES consecutive cycles, including under stall.
- HALT: pc frozen, flush=1, misalign_err=1; exit only by reset.
- Latency: a take sampled at edge N makes pc=target visible after edge N; redirect and flush are high in the cycle following edge N.
- ex_valid=0: branch_taken, jump and jalr are don't-care.

Test Plan:
- Reset: rst_n low mid-simulation, async -> pc=0, flush=0, redirect_cnt=0 before the next clk edge. Release, stall=0 -> pc 0,4,8 on successive edges.
- Taken branch: ex_valid=1, branch_taken=1, ex_pc=0x100, imm=0xFFFFFFF0 -> pc=0xF0, redirect pulses 1 cycle, flush high 2 cycles, redirect_cnt=1. A second take during FLUSH is ignored.
- JALR priority: jalr=1, jump=1, branch_taken=1, rs1=0x2001, imm=0x4, ex_pc=0x500 -> pc=0x2004 (jalr wins, bit0 cleared).
- Stall vs redirect: stall=1 with no take -> pc holds 3 cycles. stall=1 with jump, ex_pc=0x40, imm=0x20 -> pc=0x60.
- Misalignment: jump, ex_pc=0x10, imm=0x2 -> pc stays, misalign_err=1, flush stuck at 1; only rst_n recovers.
- Wrap and saturation: pc=0xFFFFFFFC with stall=0 -> pc=0. Forcing 65536 redirects -> redirect_cnt holds at 0xFFFF.
